// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_if
// Description : Hazard inputs, pipeline enables, memory handshake and
//               statistics counters of the 5-stage pipeline sequencer.
// Revision    : 1.0
// ============================================================================
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             start_i;
    logic             ex_memread_i;
    logic [4:0]       ex_rt_i;
    logic [4:0]       id_rs_i;
    logic [4:0]       id_rt_i;
    logic             id_uses_rt_i;
    logic             branch_taken_i;
    logic             jump_i;
    logic             mem_access_i;
    logic             dmem_ack_i;
    logic             pc_we_o;
    logic             ifid_we_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             pipe_we_o;
    logic             dmem_req_o;
    logic             running_o;
    logic             timeout_o;
    logic [CNT_W-1:0] cycle_cnt_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        input  start_i, ex_memread_i, ex_rt_i, id_rs_i, id_rt_i, id_uses_rt_i,
               branch_taken_i, jump_i, mem_access_i, dmem_ack_i,
        output pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o, pipe_we_o,
               dmem_req_o, running_o, timeout_o,
               cycle_cnt_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        output start_i, ex_memread_i, ex_rt_i, id_rs_i, id_rt_i, id_uses_rt_i,
               branch_taken_i, jump_i, mem_access_i, dmem_ack_i,
        input  pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o, pipe_we_o,
               dmem_req_o, running_o, timeout_o,
               cycle_cnt_o, stall_cnt_o, flush_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Central sequencer of the 5-stage pipeline: stalls, flushes,
//               data-memory freeze with timeout, saturating statistics.
// Revision    : 1.0
// ============================================================================
module pipeline_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    pipeline_ctrl_if.master  bus
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               mem_done_q, mem_done_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0]   flush_q, flush_d;

    logic w_hazard;
    logic w_pc_we, w_ifid_we, w_ifid_flush, w_idex_bubble, w_pipe_we, w_dmem_req;
    logic w_stall_inc, w_flush_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_hazard = bus.ex_memread_i && (bus.ex_rt_i != 5'd0) &&
                      ((bus.ex_rt_i == bus.id_rs_i) ||
                       (bus.id_uses_rt_i && (bus.ex_rt_i == bus.id_rt_i)));

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        mem_done_d    = mem_done_q;
        timeout_d     = timeout_q;
        w_pc_we       = 1'b0;
        w_ifid_we     = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_pipe_we     = 1'b0;
        w_dmem_req    = 1'b0;
        w_stall_inc   = 1'b0;
        w_flush_inc   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.start_i) begin
                    state_d = ST_IDLE;
                end else if (bus.mem_access_i && !mem_done_q) begin
                    w_dmem_req = 1'b1;
                    state_d    = ST_WAIT;
                    wait_d     = WAIT_W'(1);
                end else if (w_hazard) begin
                    // A concurrent branch/jump is deferred until the bubble clears.
                    w_idex_bubble = 1'b1;
                    w_pipe_we     = 1'b1;
                    w_stall_inc   = 1'b1;
                end else begin
                    w_pc_we   = 1'b1;
                    w_ifid_we = 1'b1;
                    w_pipe_we = 1'b1;
                    if (bus.branch_taken_i || bus.jump_i) begin
                        w_ifid_flush = 1'b1;
                        w_flush_inc  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                w_dmem_req = 1'b1;
                if (bus.dmem_ack_i) begin
                    state_d    = ST_RUN;
                    mem_done_d = 1'b1;
                end else if (wait_q == WAIT_W'(TIMEOUT)) begin
                    state_d    = ST_RUN;
                    mem_done_d = 1'b1;
                    timeout_d  = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Once the pipeline advances the completed access has moved on.
        if (w_pipe_we) begin
            mem_done_d = 1'b0;
        end
    end

    always_comb begin
        cycle_d = (state_q != ST_IDLE) ? sat_inc(cycle_q) : cycle_q;
        stall_d = w_stall_inc ? sat_inc(stall_q) : stall_q;
        flush_d = w_flush_inc ? sat_inc(flush_q) : flush_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            mem_done_q <= 1'b0;
            timeout_q  <= 1'b0;
            cycle_q    <= '0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            mem_done_q <= mem_done_d;
            timeout_q  <= timeout_d;
            cycle_q    <= cycle_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

    assign bus.pc_we_o       = w_pc_we;
    assign bus.ifid_we_o     = w_ifid_we;
    assign bus.ifid_flush_o  = w_ifid_flush;
    assign bus.idex_bubble_o = w_idex_bubble;
    assign bus.pipe_we_o     = w_pipe_we;
    assign bus.dmem_req_o    = w_dmem_req;
    assign bus.running_o     = (state_q != ST_IDLE);
    assign bus.timeout_o     = timeout_q;
    assign bus.cycle_cnt_o   = cycle_q;
    assign bus.stall_cnt_o   = stall_q;
    assign bus.flush_cnt_o   = flush_q;

endmodule
`default_nettype wire
